// File: rtl/delay_lcd_writer_if.sv
// Character-LCD write port: per-character write strobe with row/column/char,
// a buffer update request, and the controller's busy back-pressure.
interface delay_lcd_writer_if;
  logic       lcd_row;
  logic [3:0] lcd_col;
  logic [7:0] lcd_char;
  logic       lcd_we;
  logic       lcd_update;
  logic       lcd_busy;

  modport master (
    output lcd_row, lcd_col, lcd_char, lcd_we, lcd_update,
    input  lcd_busy
  );

  modport slave (
    input  lcd_row, lcd_col, lcd_char, lcd_we, lcd_update,
    output lcd_busy
  );
endinterface

// File: rtl/delay_lcd_writer.sv
// Renders ad1/ad2/ad_valid delays and the DIP selector as two 16-char ASCII
// rows; redraws on any input change and every REFRESH_CYCLES clocks.
module delay_lcd_writer #(
  parameter int unsigned REFRESH_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 22
) (
  input  logic                     clkcomm,
  input  logic                     RST,
  input  logic [7:0]               DIP,
  input  logic [3:0]               ad1_delay,
  input  logic [3:0]               ad2_delay,
  input  logic [3:0]               ad_valid_delay,
  delay_lcd_writer_if.master       lcd
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_UPD   = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  localparam bit              REFRESH_EN   = (REFRESH_CYCLES != 0);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

  // Snapshot layout: {dip[7:0], ad1[3:0], ad2[3:0], adv[3:0]}; idx[4] selects the row.
  function automatic logic [7:0] screen_char(input logic [4:0] idx, input logic [19:0] snap);
    logic [7:0]  dip;
    logic [23:0] sel;
    dip = snap[19:12];
    case (dip)
      8'h80:   sel = 24'h413120;
      8'h81:   sel = 24'h413220;
      8'h82:   sel = 24'h415620;
      default: sel = 24'h2D2D2D;
    endcase
    case (idx)
      5'd0:    return 8'h41;
      5'd1:    return 8'h31;
      5'd2:    return 8'h3D;
      5'd3:    return hex_ascii(snap[11:8]);
      5'd5:    return 8'h41;
      5'd6:    return 8'h32;
      5'd7:    return 8'h3D;
      5'd8:    return hex_ascii(snap[7:4]);
      5'd10:   return 8'h41;
      5'd11:   return 8'h56;
      5'd12:   return 8'h3D;
      5'd13:   return hex_ascii(snap[3:0]);
      5'd16:   return 8'h44;
      5'd17:   return 8'h49;
      5'd18:   return 8'h50;
      5'd19:   return 8'h3D;
      5'd20:   return hex_ascii(dip[7:4]);
      5'd21:   return hex_ascii(dip[3:0]);
      5'd23:   return 8'h53;
      5'd24:   return 8'h45;
      5'd25:   return 8'h4C;
      5'd26:   return 8'h3D;
      5'd27:   return sel[23:16];
      5'd28:   return sel[15:8];
      5'd29:   return sel[7:0];
      default: return 8'h20;
    endcase
  endfunction

  logic [7:0]       dip_meta_q, dip_sync_q;
  logic [19:0]      snap_q, snap_d, live_s;
  logic [2:0]       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             guard_q, guard_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             refresh_hit_s, change_s, we_s, upd_s;

  assign live_s   = {dip_sync_q, ad1_delay, ad2_delay, ad_valid_delay};
  assign change_s = (live_s != snap_q);

  // Free-running refresh counter; its wrap requests a redraw.
  always_comb begin
    cnt_d         = cnt_q;
    refresh_hit_s = 1'b0;
    if (!REFRESH_EN) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == REFRESH_LAST) begin
      cnt_d         = {CNT_W{1'b0}};
      refresh_hit_s = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Redraw sequencer; in LATCH only a same-cycle refresh can keep pending set,
  // since the live value is what gets captured.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    guard_d   = guard_q;
    snap_d    = snap_q;
    pending_d = pending_q | change_s | refresh_hit_s;
    we_s      = 1'b0;
    upd_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        snap_d    = live_s;
        pending_d = refresh_hit_s;
        idx_d     = 5'd0;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (!lcd.lcd_busy) begin
          we_s  = 1'b1;
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            state_d = ST_UPD;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_UPD: begin
        if (!lcd.lcd_busy) begin
          upd_s   = 1'b1;
          guard_d = 1'b0;
          state_d = ST_GUARD;
        end else begin
          state_d = ST_UPD;
        end
      end
      ST_GUARD: begin
        if (guard_q) begin
          state_d = ST_DRAIN;
        end else begin
          guard_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!lcd.lcd_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are qualified by lcd_busy in the same cycle so a stall never leaks a write.
  assign lcd.lcd_we     = we_s;
  assign lcd.lcd_update = upd_s;
  assign lcd.lcd_row    = we_s ? idx_q[4] : 1'b0;
  assign lcd.lcd_col    = we_s ? idx_q[3:0] : 4'd0;
  assign lcd.lcd_char   = we_s ? screen_char(idx_q, snap_q) : 8'h00;

  // State, snapshot, DIP synchroniser and refresh counter registers.
  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      dip_meta_q <= 8'h00;
      dip_sync_q <= 8'h00;
      snap_q     <= 20'h00000;
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      guard_q    <= 1'b0;
      pending_q  <= 1'b1;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      dip_meta_q <= DIP;
      dip_sync_q <= dip_meta_q;
      snap_q     <= snap_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      guard_q    <= guard_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_delay_lcd_writer.sv
// Directed and randomized checks of delay_lcd_writer against a string-level
// model of the two LCD rows.
module tb_delay_lcd_writer;
  logic       clkcomm = 1'b0;
  logic       RST;
  logic [7:0] DIP;
  logic [3:0] ad1, ad2, adv;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  always #5 clkcomm = ~clkcomm;

  delay_lcd_writer_if lcd0 ();
  delay_lcd_writer_if lcd1 ();
  assign lcd0.lcd_busy = busy;
  assign lcd1.lcd_busy = busy;

  delay_lcd_writer #(.REFRESH_CYCLES(0), .CNT_W(22)) dut0 (
    .clkcomm(clkcomm), .RST(RST), .DIP(DIP), .ad1_delay(ad1), .ad2_delay(ad2),
    .ad_valid_delay(adv), .lcd(lcd0)
  );

  delay_lcd_writer #(.REFRESH_CYCLES(100), .CNT_W(7)) dut1 (
    .clkcomm(clkcomm), .RST(RST), .DIP(DIP), .ad1_delay(ad1), .ad2_delay(ad2),
    .ad_valid_delay(adv), .lcd(lcd1)
  );

  function automatic string hx(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits.substr(int'(n), int'(n));
  endfunction

  function automatic string exp_row0(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] av);
    return {"A1=", hx(a1), " A2=", hx(a2), " AV=", hx(av), "  "};
  endfunction

  function automatic string exp_row1(input logic [7:0] d);
    string sel;
    if (d == 8'd128)      sel = "A1 ";
    else if (d == 8'd129) sel = "A2 ";
    else if (d == 8'd130) sel = "AV ";
    else                  sel = "---";
    return {"DIP=", hx(d[7:4]), hx(d[3:0]), " SEL=", sel, "  "};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  // Capture one redraw from dut0: screen contents, write count, cycles from the
  // first write to the update pulse, busy/overlap violations and order errors.
  task automatic redraw(input int stall_idx, input int stall_len, input int change_at,
                        input logic [3:0] new_ad2, output string r0, output string r1,
                        output int nw, output int span, output int viol, output int order_err);
    byte scr [32];
    int  t, stall_left;
    bit  got_upd, stalled, changed;
    for (int i = 0; i < 32; i++) scr[i] = 8'h2E;
    nw = 0; span = -1; viol = 0; order_err = 0;
    got_upd = 1'b0; stalled = 1'b0; changed = 1'b0; stall_left = 0;
    r0 = ""; r1 = "";
    t = 0;
    @(negedge clkcomm);
    while (lcd0.lcd_we !== 1'b1 && t < 300) begin
      @(negedge clkcomm);
      t++;
    end
    check("redraw_start", {31'd0, lcd0.lcd_we}, 32'd1);
    if (lcd0.lcd_we === 1'b1) begin
      t = 0;
      while (!got_upd && t < 200) begin
        if (busy && (lcd0.lcd_we || lcd0.lcd_update)) viol++;
        if (lcd0.lcd_we && lcd0.lcd_update) viol++;
        if (lcd0.lcd_we) begin
          if ({lcd0.lcd_row, lcd0.lcd_col} !== nw[4:0] || nw > 31) order_err++;
          scr[{lcd0.lcd_row, lcd0.lcd_col}] = lcd0.lcd_char;
          nw++;
        end
        if (lcd0.lcd_update) begin
          got_upd = 1'b1;
          span    = t;
        end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) busy = 1'b0;
        end else if (!stalled && stall_idx >= 0 && nw == stall_idx && !got_upd) begin
          busy       = 1'b1;
          stall_left = stall_len;
          stalled    = 1'b1;
        end
        if (!changed && change_at >= 0 && nw == change_at + 1) begin
          ad2     = new_ad2;
          changed = 1'b1;
        end
        if (!got_upd) begin
          @(negedge clkcomm);
          t++;
        end
      end
    end
    busy = 1'b0;
    for (int i = 0; i < 16; i++) r0 = $sformatf("%s%c", r0, scr[i]);
    for (int i = 16; i < 32; i++) r1 = $sformatf("%s%c", r1, scr[i]);
  endtask

  task automatic quiet(input int n, output int w);
    w = 0;
    repeat (n) begin
      @(negedge clkcomm);
      if (lcd0.lcd_we) w++;
    end
  endtask

  task automatic run_check(input string tag, input int stall_idx, input int stall_len, input int quiet_n);
    string e0, e1, r0, r1;
    int    nw, span, viol, oe, w;
    e0 = exp_row0(ad1, ad2, adv);
    e1 = exp_row1(DIP);
    redraw(stall_idx, stall_len, -1, 4'h0, r0, r1, nw, span, viol, oe);
    check_str({tag, "_row0"}, r0, e0);
    check_str({tag, "_row1"}, r1, e1);
    check({tag, "_writes"}, nw, 32);
    check({tag, "_span"}, span, 32 + ((stall_idx >= 0) ? stall_len : 0));
    check({tag, "_busy_overlap"}, viol, 0);
    check({tag, "_order"}, oe, 0);
    quiet(quiet_n, w);
    check({tag, "_quiet"}, w, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string r0, r1, old0;
    int    nw, span, viol, oe, w, t;
    int    starts[$];
    int    w0;
    bit    prev;

    RST = 1'b0; busy = 1'b0; DIP = 8'h00; ad1 = 4'h5; ad2 = 4'h0; adv = 4'h8;
    repeat (3) @(negedge clkcomm);
    check("reset_outputs", {17'd0, lcd0.lcd_row, lcd0.lcd_col, lcd0.lcd_char, lcd0.lcd_we, lcd0.lcd_update}, 32'd0);
    RST = 1'b1;
    run_check("boot", -1, 0, 150);

    ad1 = 4'h6;  run_check("ad1_6", -1, 0, 40);
    ad1 = 4'hA;  run_check("ad1_A", -1, 0, 40);
    DIP = 8'h81; run_check("dip_81", -1, 0, 40);
    DIP = 8'h82; run_check("dip_82", -1, 0, 40);
    DIP = 8'h04; run_check("dip_04", -1, 0, 40);
    DIP = 8'h80; run_check("dip_80", -1, 0, 40);

    adv = 4'h3;  run_check("stall_we", 10, 5, 40);
    adv = 4'hC;  run_check("stall_upd", 32, 3, 40);

    // ad2 changes after idx 20 is written: old value now, exactly one redraw with the new one.
    old0 = exp_row0(ad1, ad2, adv);
    ad1  = 4'h2;
    old0 = exp_row0(ad1, ad2, adv);
    redraw(-1, 0, 20, 4'h9, r0, r1, nw, span, viol, oe);
    check_str("midchg_first_row0", r0, old0);
    check("midchg_first_writes", nw, 32);
    redraw(-1, 0, -1, 4'h0, r0, r1, nw, span, viol, oe);
    check_str("midchg_second_row0", r0, exp_row0(ad1, 4'h9, adv));
    check("midchg_second_writes", nw, 32);
    quiet(60, w);
    check("midchg_quiet", w, 0);

    // Reset just before idx 15 would be written.
    DIP = 8'h00;
    t = 0; w = 0;
    while (w < 15 && t < 300) begin
      @(negedge clkcomm);
      t++;
      if (lcd0.lcd_we) w++;
    end
    check("rst_mid_progress", w, 15);
    RST = 1'b0;
    #1;
    check("rst_mid_outputs", {17'd0, lcd0.lcd_row, lcd0.lcd_col, lcd0.lcd_char, lcd0.lcd_we, lcd0.lcd_update}, 32'd0);
    @(negedge clkcomm);
    RST = 1'b1;
    run_check("post_reset", -1, 0, 40);

    for (int i = 0; i < 6; i++) begin
      int sel_pick;
      ad1 = ad1 + 4'($urandom_range(1, 15));
      ad2 = 4'($urandom_range(0, 15));
      adv = 4'($urandom_range(0, 15));
      sel_pick = $urandom_range(0, 3);
      if (sel_pick == 0)      DIP = 8'd128;
      else if (sel_pick == 1) DIP = 8'd129;
      else if (sel_pick == 2) DIP = 8'd130;
      else                    DIP = 8'($urandom_range(0, 255));
      if (i % 2 == 1) run_check($sformatf("rand%0d", i), $urandom_range(1, 32), $urandom_range(1, 4), 40);
      else            run_check($sformatf("rand%0d", i), -1, 0, 40);
    end

    // Static inputs: dut1 redraws every 100 cycles, dut0 (refresh disabled) stays silent.
    prev = 1'b0; w0 = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clkcomm);
      if (lcd1.lcd_we && !prev) starts.push_back(c);
      prev = lcd1.lcd_we;
      if (lcd0.lcd_we) w0++;
    end
    check("refresh_start_count", {31'd0, (starts.size() >= 5)}, 32'd1);
    if (starts.size() >= 5) begin
      check("refresh_interval_a", starts[3] - starts[2], 100);
      check("refresh_interval_b", starts[4] - starts[3], 100);
    end
    check("refresh_disabled_quiet", w0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
